// File: rtl/ram4x4_arbiter.sv
// ram4x4_arbiter: two-requester access controller for a 2**ADDR_W x DATA_W row RAM.
// Latency: request sampled in IDLE, row access in the next cycle (ACCESS), done/rdata in the one after (RESP).
// Backpressure: requests are sampled only in IDLE; a requester holds req until its done pulse.
//
// Ports:
//   clock, clear         - clock and synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x (x = a,b) - request, write enable, word address, write data
//   gnt_x, done_x, rdata_x - grant during ACCESS, completion pulse in RESP, captured read data
//   ram_sel, ram_rw, ram_din - one-hot row select, row write strobe, row write data
//   ram_dout             - OR of all row outputs (unselected rows drive 0)
//
// Build option: define RAM_ARB_RR_EN for round-robin tie-break (uses a 'last' register);
// otherwise A has fixed priority on a tie.
module ram4x4_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   req_a,
  input  logic                   req_b,
  input  logic                   we_a,
  input  logic                   we_b,
  input  logic [ADDR_W-1:0]      addr_a,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [DATA_W-1:0]      wdata_a,
  input  logic [DATA_W-1:0]      wdata_b,
  output logic                   gnt_a,
  output logic                   gnt_b,
  output logic                   done_a,
  output logic                   done_b,
  output logic [DATA_W-1:0]      rdata_a,
  output logic [DATA_W-1:0]      rdata_b,
  output logic [2**ADDR_W-1:0]   ram_sel,
  output logic                   ram_rw,
  output logic [DATA_W-1:0]      ram_din,
  input  logic [DATA_W-1:0]      ram_dout
);

  localparam int ROWS = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;     // 0 = A, 1 = B
  logic                op_we_q, op_we_d;
  logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;
  logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                done_a_q, done_a_d, done_b_q, done_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic [ROWS-1:0]     sel_q, sel_d;         // the latched address lives here, one-hot
  logic                rw_q, rw_d;

  logic                win_b;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

`ifdef RAM_ARB_RR_EN
  logic last_q, last_d;                      // owner of the previous transaction
  // On a tie the requester that was not served last wins.
  assign win_b = req_b & (~req_a | ~last_q);
`else
  assign win_b = req_b & ~req_a;
`endif

  assign win_we    = win_b ? we_b    : we_a;
  assign win_addr  = win_b ? addr_b  : addr_a;
  assign win_wdata = win_b ? wdata_b : wdata_a;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_we_d    = op_we_q;
    op_wdata_d = op_wdata_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    done_a_d   = 1'b0;
    done_b_d   = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    sel_d      = '0;
    rw_d       = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d         = ACCESS;
          owner_d         = win_b;
          op_we_d         = win_we;
          op_wdata_d      = win_wdata;
          // ACCESS outputs are computed here so they are registered on entry.
          gnt_a_d         = ~win_b;
          gnt_b_d         = win_b;
          sel_d[win_addr] = 1'b1;
          rw_d            = win_we;
        end
      end
      ACCESS: begin
        state_d  = RESP;
        done_a_d = ~owner_q;
        done_b_d = owner_q;
        // Selected row drives ram_dout during ACCESS; capture it on the closing edge.
        if (!op_we_q) begin
          if (owner_q) rdata_b_d = ram_dout;
          else         rdata_a_d = ram_dout;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef RAM_ARB_RR_EN
        last_d  = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      op_we_q    <= 1'b0;
      op_wdata_q <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      sel_q      <= '0;
      rw_q       <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_q     <= 1'b1;                    // B, so A wins the first tie
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_we_q    <= op_we_d;
      op_wdata_q <= op_wdata_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      sel_q      <= sel_d;
      rw_q       <= rw_d;
`ifdef RAM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign done_a  = done_a_q;
  assign done_b  = done_b_q;
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign ram_sel = sel_q;
  assign ram_rw  = rw_q;
  // Write data register holds through RESP until the next transaction is latched.
  assign ram_din = op_wdata_q;

endmodule

// File: tb/tb_ram4x4_arbiter.sv
module tb_ram4x4_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int ROWS   = 4;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic              we_a = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
  logic              gnt_a, gnt_b, done_a, done_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [ROWS-1:0]   ram_sel;
  logic              ram_rw;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  ram4x4_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .clear(clear),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_sel(ram_sel), .ram_rw(ram_rw), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Four ram1x4 rows: selected row drives its word, others drive 0; write on rising edge.
  logic [DATA_W-1:0] mem [ROWS];
  initial for (int i = 0; i < ROWS; i++) mem[i] = '0;

  always_comb begin
    ram_dout = '0;
    for (int i = 0; i < ROWS; i++)
      if (ram_sel[i]) ram_dout = ram_dout | mem[i];
  end

  always @(posedge clock)
    for (int i = 0; i < ROWS; i++)
      if (ram_sel[i] && ram_rw) mem[i] <= ram_din;

  // Scoreboard
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              qa[$];
  exp_t              qb[$];
  logic [DATA_W-1:0] ref_mem [ROWS];
  initial for (int i = 0; i < ROWS; i++) ref_mem[i] = '0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input bit b, input bit we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] d);
    exp_t e;
    e.we = we;
    if (we) begin
      ref_mem[addr] = d;
      e.data = d;
    end else begin
      e.data = ref_mem[addr];
    end
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic drive(input bit b, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] d);
    if (b) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = d;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = d;
    end
    expect_txn(b, we, addr, d);
  endtask

  // Called just after a rising edge while the DUT is in IDLE.
  task automatic txn(input bit b, input bit we, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] d);
    logic [ROWS-1:0] onehot;
    onehot = '0;
    onehot[addr] = 1'b1;
    drive(b, we, addr, d);
    @(negedge clock);                          // still IDLE
    @(negedge clock);                          // ACCESS
    chk(b ? "gnt_b access" : "gnt_a access", b ? gnt_b : gnt_a, 1);
    chk("gnt other access", b ? gnt_a : gnt_b, 0);
    chk("ram_sel access", ram_sel, onehot);
    chk("ram_rw access", ram_rw, we);
    if (we) chk("ram_din access", ram_din, d);
    @(negedge clock);                          // RESP
    chk(b ? "done_b resp" : "done_a resp", b ? done_b : done_a, 1);
    chk("gnt resp", gnt_a | gnt_b, 0);
    chk("ram_sel resp", ram_sel, 0);
    chk("ram_rw resp", ram_rw, 0);
    @(posedge clock); #1;
    if (b) req_b = 1'b0;
    else   req_a = 1'b0;
  endtask

  // Completion monitor: every done pops one expectation and checks read data.
  always @(negedge clock) begin : mon
    exp_t e;
    if (done_a) begin
      chk("done_a expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        if (!e.we) chk("rdata_a", rdata_a, e.data);
      end
    end
    if (done_b) begin
      chk("done_b expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        if (!e.we) chk("rdata_b", rdata_b, e.data);
      end
    end
    if (ram_rw) chk("ram_rw only with grant", gnt_a | gnt_b, 1);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    chk("reset gnt", {gnt_a, gnt_b}, 0);
    chk("reset done", {done_a, done_b}, 0);
    chk("reset ram_sel", ram_sel, 0);
    chk("reset ram_rw", ram_rw, 0);
    chk("reset ram_din", ram_din, 0);
    chk("reset rdata", {rdata_a, rdata_b}, 0);

    // Clear for 2 cycles in the middle of a read of addr 3: no done may follow.
    @(posedge clock); #1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd3;
    @(negedge clock);
    @(negedge clock);
    chk("gnt_a before clear", gnt_a, 1);
    clear = 1'b1;
    req_a = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    chk("clear gnt", {gnt_a, gnt_b}, 0);
    chk("clear done", {done_a, done_b}, 0);
    chk("clear ram_sel", ram_sel, 0);
    chk("clear ram_rw", ram_rw, 0);
    chk("clear ram_din", ram_din, 0);
    chk("clear rdata_a", rdata_a, 0);
    @(negedge clock);
    chk("no done after clear", {done_a, done_b}, 0);
    @(posedge clock); #1;

    // Single write / read on A
    txn(1'b0, 1'b1, 2'd2, 4'hA);
    txn(1'b0, 1'b0, 2'd2, 4'h0);

    // Row isolation
    txn(1'b0, 1'b1, 2'd0, 4'h3);
    txn(1'b1, 1'b1, 2'd3, 4'hC);
    txn(1'b0, 1'b0, 2'd0, 4'h0);
    txn(1'b1, 1'b0, 2'd3, 4'h0);
    txn(1'b0, 1'b0, 2'd1, 4'h0);

    // Busy lockout: B requests during A's ACCESS
    drive(1'b0, 1'b1, 2'd0, 4'h9);
    @(negedge clock);
    @(negedge clock);
    chk("lockout gnt_a", gnt_a, 1);
    req_b = 1'b1; we_b = 1'b0; addr_b = 2'd2;
    expect_txn(1'b1, 1'b0, 2'd2, 4'h0);
    @(negedge clock);
    chk("lockout done_a", done_a, 1);
    chk("lockout gnt_b in resp", gnt_b, 0);
    @(posedge clock); #1;
    req_a = 1'b0;
    @(negedge clock);
    chk("lockout gnt_b in idle", gnt_b, 0);
    @(negedge clock);
    chk("lockout gnt_b access", gnt_b, 1);
    chk("lockout ram_sel", ram_sel, 4'b0100);
    @(negedge clock);
    chk("lockout done_b", done_b, 1);
    @(posedge clock); #1;
    req_b = 1'b0;

    // Clear between transactions: read data registers go to 0
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    chk("clear rdata_a idle", rdata_a, 0);
    chk("clear rdata_b idle", rdata_b, 0);
    @(posedge clock); #1;

    // Tie-break with both requests held high
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 4'h6;
    req_b = 1'b1; we_b = 1'b1; addr_b = 2'd3; wdata_b = 4'h9;
    for (int k = 0; k < 4; k++) begin
      bit exp_b;
`ifdef RAM_ARB_RR_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      if (exp_b) expect_txn(1'b1, 1'b1, 2'd3, 4'h9);
      else       expect_txn(1'b0, 1'b1, 2'd2, 4'h6);
      @(negedge clock);                        // IDLE
      @(negedge clock);                        // ACCESS
      chk("tie gnt_a", gnt_a, !exp_b);
      chk("tie gnt_b", gnt_b, exp_b);
      @(negedge clock);                        // RESP
      chk("tie done", {done_a, done_b}, exp_b ? 2'b01 : 2'b10);
    end
    @(posedge clock); #1;
    req_a = 1'b0;
    req_b = 1'b0;

    // Early drop of req_a during a write of 5 to addr 1
    drive(1'b0, 1'b1, 2'd1, 4'h5);
    @(negedge clock);
    @(negedge clock);
    chk("early drop gnt_a", gnt_a, 1);
    req_a = 1'b0;
    @(negedge clock);
    chk("early drop done_a", done_a, 1);
    @(posedge clock); #1;
    txn(1'b0, 1'b0, 2'd1, 4'h0);
    txn(1'b1, 1'b0, 2'd2, 4'h0);

    repeat (3) @(negedge clock);
    chk("queue a drained", qa.size(), 0);
    chk("queue b drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
